// File: rtl/sdram_tester_pkg.sv
// ============================================================================
// Module : sdram_tester_pkg
// Brief  : State codes, address-chunk selects and defaults for the tester UC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sdram_tester_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR_MID = 4'd1,
    ST_ADDR_HI  = 4'd2,
    ST_SIZE     = 4'd3,
    ST_OPSEL    = 4'd4,
    ST_WDATA    = 4'd5,
    ST_WR_ISSUE = 4'd6,
    ST_WR_WAIT  = 4'd7,
    ST_WR_BUSY  = 4'd8,
    ST_RD_ISSUE = 4'd9,
    ST_RD_WAIT  = 4'd10,
    ST_RD_BUSY  = 4'd11,
    ST_SHOW     = 4'd12,
    ST_ERRO     = 4'd13
  } state_t;

  localparam logic [1:0] ADDR_LO   = 2'd0;
  localparam logic [1:0] ADDR_MID  = 2'd1;
  localparam logic [1:0] ADDR_HI   = 2'd2;
  localparam logic [1:0] ADDR_HOLD = 2'd3;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  function automatic logic is_wait_state(input state_t s);
    return (s == ST_WR_WAIT) || (s == ST_RD_WAIT);
  endfunction

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_WR_BUSY) || (s == ST_RD_BUSY);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_parallel_counter.sv
// ============================================================================
// Module : sync_parallel_counter
// Brief  : Free-running up counter with synchronous clear; only built when
//          SDRAM_TESTER_TIMEOUT_EN is defined (watchdog of the tester UC).
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifdef SDRAM_TESTER_TIMEOUT_EN
module sync_parallel_counter #(
  parameter int SIZE = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [SIZE-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + SIZE'(1);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/sdram_tester_uc.sv
// ============================================================================
// Module : sdram_tester_uc
// Brief  : Control unit of the SDRAM tester: turns presses and dataflow status
//          into dataflow strobes. Watchdog enabled by SDRAM_TESTER_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sdram_tester_uc
  import sdram_tester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ativado,
  input  logic       op_sel,
  input  logic       op_end,
  input  logic       busy,
  output logic       addr_en,
  output logic       size_en,
  output logic       rd_en,
  output logic       wr_en,
  output logic       wr_data_en,
  output logic       cnt_en,
  output logic       cnt_rst,
  output logic       op_rst,
  output logic [1:0] addr_src,
  output logic [3:0] estado,
  output logic       erro
);

  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  logic   w_timeout;

`ifdef SDRAM_TESTER_TIMEOUT_EN
  logic       w_wd_clear;
  logic [7:0] w_wd_count;

  // Restart the count on every state change so WAIT and BUSY get separate budgets.
  assign w_wd_clear = !(is_wait_state(r_state) || is_busy_state(r_state))
                    || (is_wait_state(r_state) && busy)
                    || (is_busy_state(r_state) && !busy);

  sync_parallel_counter #(
    .SIZE (8)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_wd_clear),
    .enable (1'b1),
    .count  (w_wd_count)
  );

  assign w_timeout = (w_wd_count == c_TIMEOUT_LAST);
  assign erro      = (r_state == ST_ERRO);
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^c_TIMEOUT_LAST;
  assign w_timeout    = 1'b0;
  assign erro         = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (ativado) r_state <= ST_ADDR_MID;
        ST_ADDR_MID: if (ativado) r_state <= ST_ADDR_HI;
        ST_ADDR_HI:  if (ativado) r_state <= ST_SIZE;
        ST_SIZE:     if (ativado) r_state <= ST_OPSEL;
        ST_OPSEL:    if (ativado) r_state <= op_sel ? ST_WDATA : ST_RD_ISSUE;
        ST_WDATA:    if (ativado && op_end) r_state <= ST_WR_ISSUE;
        ST_WR_ISSUE: if (!busy) r_state <= ST_WR_WAIT;
        ST_RD_ISSUE: if (!busy) r_state <= ST_RD_WAIT;
        ST_WR_WAIT: begin
          if (busy)           r_state <= ST_WR_BUSY;
          else if (w_timeout) r_state <= ST_ERRO;
        end
        ST_RD_WAIT: begin
          if (busy)           r_state <= ST_RD_BUSY;
          else if (w_timeout) r_state <= ST_ERRO;
        end
        ST_WR_BUSY: begin
          if (!busy)          r_state <= ST_IDLE;
          else if (w_timeout) r_state <= ST_ERRO;
        end
        ST_RD_BUSY: begin
          if (!busy)          r_state <= ST_SHOW;
          else if (w_timeout) r_state <= ST_ERRO;
        end
        ST_SHOW:     if (ativado && op_end) r_state <= ST_IDLE;
        ST_ERRO:     if (ativado) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Press strobes are Mealy: they follow ativado within the same cycle.
  always_comb begin
    addr_en    = 1'b0;
    size_en    = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wr_data_en = 1'b0;
    cnt_en     = 1'b0;
    cnt_rst    = 1'b0;
    op_rst     = 1'b0;
    addr_src   = ADDR_HOLD;
    case (r_state)
      ST_IDLE: begin
        cnt_rst = 1'b1;
        op_rst  = 1'b1;
        if (ativado) begin
          addr_en  = 1'b1;
          addr_src = ADDR_LO;
        end
      end
      ST_ADDR_MID: begin
        if (ativado) begin
          addr_en  = 1'b1;
          addr_src = ADDR_MID;
        end
      end
      ST_ADDR_HI: begin
        if (ativado) begin
          addr_en  = 1'b1;
          addr_src = ADDR_HI;
        end
      end
      ST_SIZE:  size_en = ativado;
      ST_OPSEL: cnt_rst = 1'b1;
      ST_WDATA: begin
        wr_data_en = ativado;
        cnt_en     = ativado;
      end
      ST_WR_ISSUE: begin
        cnt_rst = 1'b1;
        wr_en   = !busy;
      end
      ST_RD_ISSUE: begin
        cnt_rst = 1'b1;
        rd_en   = !busy;
      end
      ST_WR_BUSY, ST_RD_BUSY: op_rst = 1'b1;
      ST_SHOW: cnt_en = ativado && !op_end;
      ST_ERRO: begin
        cnt_rst = 1'b1;
        op_rst  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign estado = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sdram_tester_uc.sv
// ============================================================================
// Module : tb_sdram_tester_uc
// Brief  : Self-checking bench for sdram_tester_uc (vector table, directed
//          corner cases, randomized operations against a transaction model).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sdram_tester_uc;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ativado = 1'b0;
  logic       op_sel = 1'b0;
  logic       busy = 1'b0;
  logic       op_end;
  logic       addr_en, size_en, rd_en, wr_en, wr_data_en, cnt_en, cnt_rst, op_rst, erro;
  logic [1:0] addr_src;
  logic [3:0] estado;

  sdram_tester_uc dut (
    .clock      (clock),
    .reset      (reset),
    .ativado    (ativado),
    .op_sel     (op_sel),
    .op_end     (op_end),
    .busy       (busy),
    .addr_en    (addr_en),
    .size_en    (size_en),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .wr_data_en (wr_data_en),
    .cnt_en     (cnt_en),
    .cnt_rst    (cnt_rst),
    .op_rst     (op_rst),
    .addr_src   (addr_src),
    .estado     (estado),
    .erro       (erro)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Dataflow byte counter: op_end flags the last byte of the transfer.
  int df_cnt;
  int df_nbytes = 1;
  bit op_end_manual_en = 1'b1;
  bit op_end_manual = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset)       df_cnt <= 0;
    else if (cnt_rst) df_cnt <= 0;
    else if (cnt_en)  df_cnt <= df_cnt + 1;
  end

  assign op_end = op_end_manual_en ? op_end_manual : (df_cnt == df_nbytes - 1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {estado, addr_en, addr_src, size_en, wr_data_en, cnt_en,
            cnt_rst, op_rst, wr_en, rd_en, erro};
  endfunction

  typedef struct packed {
    logic        a;
    logic        os;
    logic        oe;
    logic        b;
    logic [14:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit a, input bit os, input bit oe, input bit b,
                              input logic [3:0] est, input bit ae, input logic [1:0] src,
                              input bit se, input bit wde, input bit ce, input bit cr,
                              input bit orr, input bit we, input bit re);
    vec_t v;
    v.a   = a;
    v.os  = os;
    v.oe  = oe;
    v.b   = b;
    v.exp = {est, ae, src, se, wde, ce, cr, orr, we, re, 1'b0};
    return v;
  endfunction

  // Transaction tallies gathered by cycle()
  int         t_addr, t_size, t_wrd, t_cnt, t_wr, t_rd, t_consec, t_busy_issue, t_oprst_bad;
  logic [1:0] t_src[$];
  bit         prev_issue;

  task automatic cycle(input bit a, input bit b, input bit rnd);
    @(negedge clock);
    ativado = rnd ? (($urandom % 2 == 1) && estado >= 4'd6 && estado <= 4'd11) : a;
    busy    = b;
    #1;
    if (addr_en) begin
      t_addr++;
      t_src.push_back(addr_src);
    end
    if (size_en)    t_size++;
    if (wr_data_en) t_wrd++;
    if (cnt_en)     t_cnt++;
    if (wr_en)      t_wr++;
    if (rd_en)      t_rd++;
    if (wr_en || rd_en) begin
      if (prev_issue) t_consec++;
      if (busy)       t_busy_issue++;
    end
    if ((estado == 4'd8 || estado == 4'd11) && !op_rst) t_oprst_bad++;
    prev_issue = wr_en || rd_en;
  endtask

  task automatic press(input int gap);
    repeat (gap) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  // One complete user operation; checks the strobe totals the operation must produce.
  task automatic do_op(input bit is_wr, input int nbytes, input int pre_busy,
                       input int rise_dly, input int busy_len);
    int         pre_left, since, guard;
    bit         issued, b;
    logic [3:0] target;
    t_addr = 0; t_size = 0; t_wrd = 0; t_cnt = 0; t_wr = 0; t_rd = 0;
    t_consec = 0; t_busy_issue = 0; t_oprst_bad = 0; prev_issue = 0;
    t_src.delete();
    df_nbytes = nbytes;
    op_end_manual_en = 1'b0;
    op_sel = is_wr;
    for (int i = 0; i < 3; i++) begin
      press($urandom_range(0, 2));
      chk("op_addr_src", addr_src, i);
      chk("op_addr_state", estado, i);
    end
    press($urandom_range(0, 2));
    chk("op_size_state", estado, 3);
    press($urandom_range(0, 2));
    chk("op_opsel_state", estado, 4);
    if (is_wr)
      for (int k = 0; k < nbytes; k++) press($urandom_range(0, 2));
    target   = is_wr ? 4'd0 : 4'd12;
    pre_left = pre_busy;
    since    = 0;
    issued   = 0;
    guard    = 0;
    while (!(issued && estado == target) && guard < 300) begin
      b = 0;
      if (!issued) begin
        if (pre_left > 0) begin
          b = 1;
          pre_left--;
        end
      end else if (since >= rise_dly && since < rise_dly + busy_len) begin
        b = 1;
      end
      cycle(1'b0, b, 1'b1);
      if (issued) since++;
      if (wr_en || rd_en) issued = 1;
      guard++;
    end
    chk("op_issue_phase_done", guard < 300, 1);
    if (!is_wr) begin
      for (int k = 0; k < nbytes; k++) press($urandom_range(0, 2));
      cycle(1'b0, 1'b0, 1'b0);
      chk("op_show_exit_state", estado, 0);
    end
    chk("op_addr_en_count", t_addr, 3);
    chk("op_addr_src_seq", (t_src.size() == 3) ? {t_src[0], t_src[1], t_src[2]} : 6'h3f, 6'b000110);
    chk("op_size_en_count", t_size, 1);
    chk("op_wr_data_en_count", t_wrd, is_wr ? nbytes : 0);
    chk("op_cnt_en_count", t_cnt, is_wr ? nbytes : nbytes - 1);
    chk("op_wr_en_count", t_wr, is_wr ? 1 : 0);
    chk("op_rd_en_count", t_rd, is_wr ? 0 : 1);
    chk("op_issue_back_to_back", t_consec, 0);
    chk("op_issue_while_busy", t_busy_issue, 0);
    chk("op_op_rst_in_busy", t_oprst_bad, 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   n7;

    // Walk one 1-byte write and one 1-byte read cycle by cycle.
    tbl.push_back(mk(0,0,0,0, 0, 0,3,0,0,0,1,1,0,0));
    tbl.push_back(mk(1,0,0,0, 0, 1,0,0,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0, 1, 0,3,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 1, 1,1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 2, 1,2,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 3, 0,3,1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 4, 0,3,0,0,0,1,0,0,0));
    tbl.push_back(mk(1,1,0,0, 4, 0,3,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 5, 0,3,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,0, 5, 0,3,0,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 6, 0,3,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 6, 0,3,0,0,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0, 7, 0,3,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 7, 0,3,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 8, 0,3,0,0,0,0,1,0,0));
    tbl.push_back(mk(1,0,0,0, 8, 0,3,0,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,3,0,0,0,1,1,0,0));
    tbl.push_back(mk(1,0,0,0, 0, 1,0,0,0,0,1,1,0,0));
    tbl.push_back(mk(1,0,0,0, 1, 1,1,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 2, 1,2,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 3, 0,3,1,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 4, 0,3,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 9, 0,3,0,0,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,10, 0,3,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,11, 0,3,0,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,12, 0,3,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,12, 0,3,0,0,1,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,12, 0,3,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0, 0,3,0,0,0,1,1,0,0));

    #1;
    chk("reset_state", outs(), {4'd0, 1'b0, 2'd3, 5'b00011, 3'b000});
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      ativado       = tbl[i].a;
      op_sel        = tbl[i].os;
      op_end_manual = tbl[i].oe;
      busy          = tbl[i].b;
      #1;
      chk($sformatf("vec_%0d", i), outs(), tbl[i].exp);
    end

    // Asynchronous reset while showing read data
    op_end_manual = 1'b0;
    op_sel        = 1'b0;
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    ativado = 1'b0;
    #1;
    chk("show_before_reset", estado, 12);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), {4'd0, 1'b0, 2'd3, 5'b00011, 3'b000});
    @(negedge clock);
    reset = 1'b1;

    do_op(1'b1, 4, 0, 0, 10);
    do_op(1'b0, 1, 5, 1, 4);
    for (int r = 0; r < 16; r++)
      do_op($urandom % 2 == 1, 1 << ($urandom % 4), $urandom_range(0, 4),
            $urandom_range(0, 3), $urandom_range(1, 12));

    // Write issued but the controller never turns busy
    op_end_manual_en = 1'b1;
    op_end_manual    = 1'b1;
    op_sel           = 1'b1;
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("timeout_wr_en", wr_en, 1);
    n7 = 0;
    for (int k = 0; k < 400; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (estado != 4'd7) break;
      n7++;
    end
`ifdef SDRAM_TESTER_TIMEOUT_EN
    chk("timeout_wait_cycles", n7, 255);
    chk("timeout_state", estado, 13);
    chk("timeout_erro", erro, 1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("erro_exit_state", estado, 0);
    chk("erro_exit_flag", erro, 0);
`else
    chk("no_timeout_wait_cycles", n7, 400);
    chk("no_timeout_state", estado, 7);
    chk("no_timeout_erro", erro, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
